seq_multiplier: RTL and testbench

//  Parametrised sequential shift-add multiplier; successor to the combinational multiplier.

---
 rtl/seq_mult_pkg.sv | 19 +
 rtl/seq_multiplier_if.sv | 14 +
 rtl/seq_mult_datapath.sv | 39 +++
 rtl/seq_multiplier.sv | 95 +++++++++
 tb/tb_seq_multiplier.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// Optional signed mode is selected in the top with SEQ_MULT_SIGNED_EN.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Counter must reach WIDTH-1; never let it collapse to zero bits.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of seq_multiplier.
interface seq_multiplier_if #(parameter int WIDTH = 4);

  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] Product;

  modport master (output start, A, B, input busy, done, Product);
  modport slave  (input start, A, B, output busy, done, Product);

endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: acc/mcand/mplier registers with load and step controls.
// acc_nxt exposes the accumulator value this step would write, for write-back.
module seq_mult_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_nxt
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= PW'(a);
      mplier <= b;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier top: FSM, iteration counter, handshake and result.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands and product.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  seq_multiplier_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             accept, step, last;
  logic             busy, done;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] a_op, b_op;
  logic [PW-1:0]    acc_nxt, result;

  assign accept = (state == IDLE) && bus.start;
  assign step   = (state == RUN);
  assign last   = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  logic sign;

  // Magnitudes feed the unsigned core; -2^(W-1) negates to itself, which is
  // exactly its magnitude when read as unsigned.
  assign a_op   = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign b_op   = bus.B[WIDTH-1] ? -bus.B : bus.B;
  assign result = sign ? -acc_nxt : acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sign <= 1'b0;
    else if (accept) sign <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
  end
`else
  assign a_op   = bus.A;
  assign b_op   = bus.B;
  assign result = acc_nxt;
`endif

  seq_mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .step    (step),
    .a       (a_op),
    .b       (b_op),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // No early exit: every op runs the full WIDTH iterations for fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (accept) cnt <= '0;
    else if (step)   cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= step && last;
      if (step && last) product <= result;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.Product = product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier at WIDTH=4 and WIDTH=8.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(4)) bus4 ();
  seq_multiplier_if #(.WIDTH(8)) bus8 ();

  seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [7:0]  P15X15 = 8'd1;
  localparam logic [7:0]  P10X5  = 8'hE2;
  localparam logic [7:0]  P7X9   = 8'hCF;
  localparam logic [15:0] P255SQ = 16'd1;
`else
  localparam logic [7:0]  P15X15 = 8'd225;
  localparam logic [7:0]  P10X5  = 8'd50;
  localparam logic [7:0]  P7X9   = 8'd63;
  localparam logic [15:0] P255SQ = 16'd65025;
`endif

  logic [3:0] seq_a [3] = '{4'd15, 4'd0, 4'd10};
  logic [3:0] seq_b [3] = '{4'd15, 4'd15, 4'd5};
  logic [7:0] seq_p [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    logic [15:0] p;
    p = a * b;
    return p;
`endif
  endfunction

  // One op with a single-cycle start; checks latency, busy span, product, return to idle.
  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp);
    int edges;
    int busy_cyc;
    edges = 0;
    busy_cyc = 0;
    bus4.A = a; bus4.B = b; bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    while (!bus4.done && edges < 20) begin
      if (bus4.busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
    if (bus4.busy) busy_cyc++;
    check({tag, "_lat"}, edges + 1, 5);
    check({tag, "_busy"}, busy_cyc, 5);
    check({tag, "_prod"}, 32'(bus4.Product), 32'(exp));
    @(posedge clk); #1;
    check({tag, "_idle"}, {bus4.busy, bus4.done}, 0);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int edges;
    edges = 0;
    bus8.A = a; bus8.B = b; bus8.start = 1'b1;
    @(posedge clk); #1 bus8.start = 1'b0;
    bus8.A = ~a; bus8.B = ~b;
    while (!bus8.done && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_lat"}, edges + 1, 9);
    check({tag, "_prod"}, 32'(bus8.Product), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    int t, last_t, guard;
    logic [7:0] ra, rb;
    seq_p[0] = P15X15; seq_p[1] = 8'd0; seq_p[2] = P10X5;
    bus4.start = 1'b0; bus4.A = '0; bus4.B = '0;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;

    #12;
    check("rst4_busy", bus4.busy, 0);
    check("rst4_done", bus4.done, 0);
    check("rst4_prod", 32'(bus4.Product), 0);
    check("rst8_busy", bus8.busy, 0);
    check("rst8_prod", 32'(bus8.Product), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    op4("t1_3x2", 4'd3, 4'd2, 8'd6);

    // Start held high: ops re-accepted on the first IDLE edge, one per 6 cycles.
    t = 0; last_t = 0;
    bus4.A = seq_a[0]; bus4.B = seq_b[0]; bus4.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      guard = 0;
      do begin
        @(posedge clk); #1;
        t++; guard++;
      end while (!bus4.done && guard < 20);
      check($sformatf("t2_prod%0d", i), 32'(bus4.Product), 32'(seq_p[i]));
      if (i > 0) check($sformatf("t2_gap%0d", i), t - last_t, 6);
      last_t = t;
      if (i < 2) begin
        bus4.A = seq_a[i+1]; bus4.B = seq_b[i+1];
      end
    end
    bus4.start = 1'b0;
    @(posedge clk); #1;
    check("t2_idle", bus4.busy, 0);

    // Start pulses in RUN and DONE are ignored; operand changes mid-RUN have no effect.
    bus4.A = 4'd7; bus4.B = 4'd9; bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    @(posedge clk); #1;
    bus4.A = 4'd1; bus4.B = 4'd1; bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    guard = 0;
    while (!bus4.done && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("t3_done_seen", bus4.done, 1);
    check("t3_prod", 32'(bus4.Product), 32'(P7X9));
    bus4.A = 4'd2; bus4.B = 4'd2; bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    check("t3_ign_done", bus4.busy, 0);
    @(posedge clk); #1;
    check("t3_still_idle", {bus4.busy, bus4.done}, 0);
    check("t3_prod_hold", 32'(bus4.Product), 32'(P7X9));

    // Reset asserted ahead of the 2nd RUN edge aborts the op.
    bus4.A = 4'd5; bus4.B = 4'd3; bus4.start = 1'b1;
    @(posedge clk); #1 bus4.start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t4_rst_prod", 32'(bus4.Product), 0);
    check("t4_rst_busy", bus4.busy, 0);
    check("t4_rst_done", bus4.done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("t4_nodone%0d", i), {bus4.busy, bus4.done}, 0);
    end
    op4("t4_new", 4'd5, 4'd3, 8'd15);

    op8("t5_max", 8'd255, 8'd255, P255SQ);
    op8("t5_zero", 8'd0, 8'd200, 16'd0);
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8($sformatf("t5_rnd%0d", i), ra, rb, ref8(ra, rb));
    end

`ifdef SEQ_MULT_SIGNED_EN
    op4("t6_m3x5", 4'hD, 4'd5, 8'hF1);
    op4("t6_m8xm8", 4'h8, 4'h8, 8'd64);
    op4("t6_m8x7", 4'h8, 4'd7, 8'hC8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule
